alu_result_pipe: RTL

//   Parametrised, registered successor to the ALU result multiplexer. Decodes ALUControl into one of NSRC result sources.

---
 rtl/alu_sel_pkg.sv | 53 +++++
 rtl/res_skid_buf.sv | 66 ++++++
 rtl/alu_result_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/alu_sel_pkg.sv
// ALU result-select package: operation codes, source indices and the code-to-source decode.
package alu_sel_pkg;

   localparam int unsigned SRC_IDX_W = 4;

   localparam logic [3:0] ALU_ADD      = 4'b0000;
   localparam logic [3:0] ALU_SUB      = 4'b0001;
   localparam logic [3:0] ALU_AND      = 4'b0010;
   localparam logic [3:0] ALU_OR       = 4'b0011;
   localparam logic [3:0] ALU_XOR      = 4'b0100;
   localparam logic [3:0] ALU_LUI      = 4'b0110;
   localparam logic [3:0] ALU_SLL      = 4'b0101;
   localparam logic [3:0] ALU_SRL      = 4'b0111;
   localparam logic [3:0] ALU_SRA      = 4'b1101;
   localparam logic [3:0] ALU_ROR      = 4'b1111;
   localparam logic [3:0] ALU_EXT_BASE = 4'b1000;

   localparam logic [SRC_IDX_W-1:0] SRC_AS   = SRC_IDX_W'(0);
   localparam logic [SRC_IDX_W-1:0] SRC_AND  = SRC_IDX_W'(1);
   localparam logic [SRC_IDX_W-1:0] SRC_OR   = SRC_IDX_W'(2);
   localparam logic [SRC_IDX_W-1:0] SRC_XOR  = SRC_IDX_W'(3);
   localparam logic [SRC_IDX_W-1:0] SRC_LUI  = SRC_IDX_W'(4);
   localparam logic [SRC_IDX_W-1:0] SRC_SH   = SRC_IDX_W'(5);
   localparam logic [SRC_IDX_W-1:0] SRC_EXT0 = SRC_IDX_W'(6);

   // Returns {illegal, source index}; extension codes are legal only when that unit exists.
   function automatic logic [SRC_IDX_W:0] alu_decode(input logic [3:0] code,
                                                     input int unsigned nsrc);
      logic                 ill;
      logic [SRC_IDX_W-1:0] idx;
      int unsigned          ext_k;
      ill   = 1'b0;
      idx   = SRC_AS;
      ext_k = 32'(code - ALU_EXT_BASE);
      case (code)
         ALU_ADD, ALU_SUB:                 idx = SRC_AS;
         ALU_AND:                          idx = SRC_AND;
         ALU_OR:                           idx = SRC_OR;
         ALU_XOR:                          idx = SRC_XOR;
         ALU_LUI:                          idx = SRC_LUI;
         ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR: idx = SRC_SH;
         default: begin
            if ((code >= ALU_EXT_BASE) && ((32'd6 + ext_k) < nsrc)) begin
               idx = SRC_EXT0 + SRC_IDX_W'(ext_k);
            end else begin
               ill = 1'b1;
            end
         end
      endcase
      return {ill, idx};
   endfunction

endpackage

// File: rtl/res_skid_buf.sv
// Two-entry valid/ready buffer; head entry is always presented on out_data.
module res_skid_buf #(
   parameter int unsigned DW = 33
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic [DW-1:0] mem_q [2];
   logic [DW-1:0] mem_d [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;
   logic          push;
   logic          pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next-state: write tail on push, advance head on pop; 1-bit pointers wrap naturally.
   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_result_pipe.sv
// Registered ALU result select: decode ALUControl, pick a source, buffer it on valid/ready.
// Define ALU_RESULT_FLAGS_EN to add per-entry out_zero/out_neg flags.
module alu_result_pipe
   import alu_sel_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [3:0]            ALUControl,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
`ifdef ALU_RESULT_FLAGS_EN
   output logic                  out_zero,
   output logic                  out_neg,
`endif
   output logic                  out_illegal
);

`ifdef ALU_RESULT_FLAGS_EN
   localparam int unsigned FLAG_W = 2;
`else
   localparam int unsigned FLAG_W = 0;
`endif
   localparam int unsigned DW = WIDTH + 1 + FLAG_W;

   logic [SRC_IDX_W:0]   dec;
   logic                 dec_ill;
   logic [SRC_IDX_W-1:0] dec_idx;
   logic [WIDTH-1:0]     sel_data;
   logic [DW-1:0]        entry_in;
   logic [DW-1:0]        entry_head;

   assign dec     = alu_decode(ALUControl, NSRC);
   assign dec_ill = dec[SRC_IDX_W];
   assign dec_idx = dec[SRC_IDX_W-1:0];

   // Source mux; an illegal code forces zero data.
   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (dec_idx == SRC_IDX_W'(k)) begin
            sel_data = src_data[k*WIDTH +: WIDTH];
         end
      end
      if (dec_ill) begin
         sel_data = '0;
      end
   end

`ifdef ALU_RESULT_FLAGS_EN
   assign entry_in = {sel_data[WIDTH-1], (sel_data == '0), dec_ill, sel_data};
`else
   assign entry_in = {dec_ill, sel_data};
`endif

   res_skid_buf #(.DW(DW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (entry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (entry_head)
   );

   assign out_data    = entry_head[WIDTH-1:0];
   assign out_illegal = entry_head[WIDTH];
`ifdef ALU_RESULT_FLAGS_EN
   assign out_zero    = entry_head[WIDTH+1];
   assign out_neg     = entry_head[WIDTH+2];
`endif

endmodule
